// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, with pipeline stall and a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sA_q, sA_d, sB_q, sB_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               signA, signB, divZero, divOvf;
  logic [WIDTH-1:0]   magA, magB, fastVal;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFinal;
  logic [WIDTH-1:0]   remSub, quoFinal, remFinal, finalVal;
  logic               divGe;

  always_comb begin
    signA   = SrcA[WIDTH-1] && (Funct3 == 3'b001 || Funct3 == 3'b010 ||
                                Funct3 == 3'b100 || Funct3 == 3'b110);
    signB   = SrcB[WIDTH-1] && (Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110);
    magA    = signA ? -SrcA : SrcA;
    magB    = signB ? -SrcB : SrcB;
    divZero = Funct3[2] && (SrcB == '0);
    divOvf  = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    fastVal = '0;
    if (divZero)
      fastVal = Funct3[1] ? SrcA : '1;
    else if (divOvf)
      fastVal = Funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of each datapath; the low half holds multiplier bits or quotient bits.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    mulNext  = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    divGe    = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, mcand_q};
    remSub   = acc_q[2*WIDTH-2:WIDTH-1] - mcand_q;
    divNext  = divGe ? {remSub, acc_q[WIDTH-2:0], 1'b1}
                     : {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
    prodFinal = (sA_q ^ sB_q) ? -mulNext : mulNext;
    quoFinal  = (sA_q ^ sB_q) ? -divNext[WIDTH-1:0] : divNext[WIDTH-1:0];
    remFinal  = sA_q ? -divNext[2*WIDTH-1:WIDTH] : divNext[2*WIDTH-1:WIDTH];
    if (op_q[2])
      finalVal = op_q[1] ? remFinal : quoFinal;
    else
      finalVal = (op_q[1:0] == 2'b00) ? prodFinal[WIDTH-1:0] : prodFinal[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sA_d     = sA_q;
    sB_d     = sB_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = Funct3;
            sA_d    = signA;
            sB_d    = signB;
            acc_d   = {{WIDTH{1'b0}}, magA};
            mcand_d = magB;
            cnt_d   = CNT_INIT;
            if (divZero || divOvf) begin
              result_d = fastVal;
              state_d  = DONE;
            end else begin
              state_d = COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc_d = op_q[2] ? divNext : mulNext;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = finalVal;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sA_q     <= 1'b0;
      sB_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sA_q     <= sA_d;
      sB_q     <= sB_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == COMPUTE) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign stall  = (start && (state_q == IDLE)) || (state_q == COMPUTE);
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/ignored-start sequences.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, stall, done;
  logic [31:0] Result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference results straight from RV32M arithmetic on 64-bit and int values.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] au, as, bu, bs, p;
    int ia, ib;
    au = {32'b0, a};
    as = {{32{a[31]}}, a};
    bu = {32'b0, b};
    bs = {{32{b[31]}}, b};
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = au * bu; return p[31:0]; end
      3'b001: begin p = as * bs; return p[63:32]; end
      3'b010: begin p = as * bu; return p[63:32]; end
      3'b011: begin p = au * bu; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || ((op == 3'b100 || op == 3'b110) &&
                                a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Issues one op from an IDLE cycle and follows it to the IDLE cycle after DONE.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input bit noise, input string nm);
    int expCycle, doneCycle;
    logic [31:0] prevResult;
    bit stallOk, holdOk;
    expCycle   = isFast(op, a, b) ? 1 : WIDTH + 1;
    prevResult = Result;
    stallOk    = 1'b1;
    holdOk     = 1'b1;
    doneCycle  = -1;
    Funct3 = op;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
    #1;
    checkOutput({nm, "_stall_accept"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= WIDTH + 4; c++) begin
      if (done) begin
        doneCycle = c;
        break;
      end
      if (!stall) stallOk = 1'b0;
      if (Result !== prevResult) holdOk = 1'b0;
      if (noise && (c == 5 || c == 12)) begin
        start  = 1'b1;
        Funct3 = 3'($urandom_range(0, 7));
        SrcA   = $urandom;
        SrcB   = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput({nm, "_done_cycle"}, doneCycle, expCycle);
    checkOutput({nm, "_result"}, Result, exp);
    checkOutput({nm, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    checkOutput({nm, "_stall_compute"}, {31'b0, stallOk}, 32'd1);
    checkOutput({nm, "_result_hold_before"}, {31'b0, holdOk}, 32'd1);
    @(posedge clk); #1;
    checkOutput({nm, "_idle_busy"}, {30'b0, busy, done}, 32'd0);
    checkOutput({nm, "_result_hold_after"}, Result, exp);
  endtask

  initial begin
    logic [31:0] prev, ra, rb;
    logic [2:0]  rop;
    bit          noDone;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[13] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    Funct3 = 3'b0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_outputs", {29'b0, busy, done, stall}, 32'd0);
    checkOutput("reset_result", Result, 32'd0);

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // flush and start together in IDLE: flush wins, nothing is accepted
    Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_idle", {30'b0, busy, done}, 32'd0);

    // flush in cycle 10 of a DIV, then restart in cycle 11
    prev = Result;
    noDone = 1'b1;
    Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) noDone = 1'b0;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_no_done_pulse", {31'b0, noDone}, 32'd1);
    checkOutput("flush_idle", {30'b0, busy, done}, 32'd0);
    checkOutput("flush_result_kept", Result, prev);
    applyStimulus(3'b000, 32'd12345, 32'd678, refModel(3'b000, 32'd12345, 32'd678), 1'b0,
                  "flush_restart");

    // start pulses during COMPUTE must not disturb the op in flight
    applyStimulus(3'b100, 32'hFFFFF000, 32'd7, refModel(3'b100, 32'hFFFFF000, 32'd7), 1'b1,
                  "ignored_start");

    // reset in cycle 5 of a DIV
    Funct3 = 3'b100; SrcA = 32'd77; SrcB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_outputs", {29'b0, busy, done, stall}, 32'd0);
    checkOutput("midreset_result", Result, 32'd0);
    reset = 1'b0;
    applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, "post_reset_mul");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = 32'd0;
        2:    begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3:    rb = $urandom_range(1, 20);
        4:    ra = $urandom_range(0, 50);
        default: ;
      endcase
      applyStimulus(rop, ra, rb, refModel(rop, ra, rb), i[0], $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and iterates a radix-2 shift-add multiplier or a restoring divider over WIDTH cycles. While it works, it holds the pipeline through a stall output. It returns a registered result with a one-cycle done pulse.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- start  in  1  request, sampled only in IDLE; operands and Funct3 valid in the same cycle
- Funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  WIDTH  rs1 operand
- SrcB  in  WIDTH  rs2 operand
- flush  in  1  abort the current operation (branch mispredict/trap)
- busy  out  1  high in COMPUTE and DONE
- stall  out  1  pipeline hold: (start && state==IDLE) || state==COMPUTE; combinational
- done  out  1  one-cycle pulse, high exactly in DONE
- Result  out  WIDTH  registered result; holds its value until the next DONE

## Operation
- **States:**
  - IDLE -> COMPUTE on start, or IDLE -> DONE on start with a fast-path case.
  - COMPUTE -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE unconditionally.
- **Accept (IDLE, start=1):**
  - Latch the op.
  - Latch the sign flags: sA = SrcA[MSB] for MULH/MULHSU/DIV/REM; sB = SrcB[MSB] for MULH/DIV/REM. All other ops treat operands as unsigned.
  - Latch magnitudes |SrcA| and |SrcB| (two's-complement negate when the sign flag is set).
  - Load counter = WIDTH.
- **Multiply:** 2*WIDTH-bit accumulator. Each COMPUTE cycle: if multiplier LSB is 1, add the multiplicand into the upper half; then shift right 1.
  - At the COMPUTE->DONE edge, negate the 2*WIDTH product if sA^sB.
  - Result = low half for MUL, high half for MULH/MULHSU/MULHU.
- **Divide:** restoring. Each cycle: shift {rem, quo} left 1, trial-subtract the divisor, keep the result and set quo LSB if it is non-negative.
  - Final quotient is negated if sA^sB; final remainder is negated if sA.
  - Result = quotient for DIV/DIVU, remainder for REM/REMU.
- **Fast paths** (decided at accept, skip COMPUTE):
  - Divisor 0: quotient = all ones, remainder = SrcA.
  - Signed overflow (DIV/REM, SrcA = 0x80000000, SrcB = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- **Signed MULHSU:** only SrcA is signed.
- **flush:** from any state, next state is IDLE; done is not asserted; Result is unchanged. flush has priority over start in the same cycle.
- **start outside IDLE:** ignored, with no side effects.
- **reset:** state IDLE, counter 0, busy 0, done 0, Result 0, internal accumulators 0. Reset has priority over flush and start.

## Timing
- Normal op, start high in cycle 0:
  - Cycles 1..WIDTH: COMPUTE (32 cycles at the default WIDTH).
  - Cycle WIDTH+1: DONE, done=1, Result valid.
  - Cycle WIDTH+2: IDLE.
- Fast path: cycle 1 DONE; cycle 2 IDLE.
- stall is high in cycles 0..WIDTH and low in DONE, so the pipeline advances and captures Result in the DONE cycle.
- A new start is accepted in the first IDLE cycle after DONE, so back-to-back issue is WIDTH+2 cycles apart.
- Reset mid-operation: all outputs are at reset values in the cycle after the reset edge.

## Test plan
- **MUL 7 x 0xFFFFFFFD (-3):** Result 0xFFFFFFEB; done only in cycle 33; stall high in cycles 0-32.
- **High products:**
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- **Signed divide:** DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- **Fast paths:** done in cycle 1 for each.
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- **Flush and restart:** flush in cycle 10 of a DIV.
  - IDLE in cycle 11; no done pulse; Result keeps its old value.
  - A start in cycle 11 is accepted and completes correctly.
- **Ignored start and reset:**
  - start pulses during COMPUTE are ignored; result and timing are unchanged.
  - reset in cycle 5 gives busy/done/stall 0 and Result 0 in cycle 6.
  - A following MUL 3x4 -> 12 completes normally.
